sipo_frame_deser: RTL

Parametrised serial-to-parallel frame deserialiser with an internal beat counter, valid/ready handshakes on both sides, and a double buffer. It sits between the serial triangle-data link and the triangle setup stage. It assembles FRAME_BITS-wide frames (default 144 bits, one triangle) from LANES-bit beats. A completed frame is held stable until the consumer accepts it, while the next frame continues to fill. A start-of-frame marker resynchronises framing and flags any partial frame it discards.

---
 rtl/sipo_pkg.sv | 12 +
 rtl/sipo_frame_deser_shift_core.sv | 86 ++++++++
 rtl/sipo_frame_deser.sv | 80 ++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared constants, shift-side state encoding and sizing helper for the
// serial-to-parallel frame deserialiser.
package sipo_pkg;
    localparam int FRAME_BITS_DEF = 144;
    localparam int LANES_DEF      = 1;

    typedef enum logic {FILL, FULL} shift_state_t;

    function automatic int beats(input int frame, input int lanes);
        return frame / lanes;
    endfunction
endpackage

// File: rtl/sipo_frame_deser_shift_core.sv
// Shift-side of the deserialiser: beat assembly, framing counter, start-of-frame
// resync and the FILL/FULL hand-off to the output register.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int LANES      = LANES_DEF,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [LANES-1:0]      in_data,
    input  logic                  out_free,
    output logic                  in_ready,
    output logic                  frame_done,
    output logic [FRAME_BITS-1:0] frame_bits,
    output logic                  sync_err
);
    localparam int BEATS = beats(FRAME_BITS, LANES);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    shift_state_t          state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d, eff_cnt;
    logic [FRAME_BITS-1:0] shift_q, shift_d, shifted;
    logic                  sync_err_q, sync_err_d;

    assign in_ready = (state_q == FILL);
    assign sync_err = sync_err_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        shift_d    = shift_q;
        sync_err_d = 1'b0;
        frame_done = 1'b0;
        frame_bits = shift_q;
        eff_cnt    = beat_cnt_q;
        shifted    = MSB_FIRST ? ((shift_q << LANES) | FRAME_BITS'(in_data))
                               : ((shift_q >> LANES) | (FRAME_BITS'(in_data) << (FRAME_BITS - LANES)));
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    shift_d    = shifted;
                    // sof forces this beat to be beat 0; older bits age out of the register
                    eff_cnt    = in_sof ? '0 : beat_cnt_q;
                    sync_err_d = in_sof && (beat_cnt_q != '0);
                    if (eff_cnt == LAST) begin
                        beat_cnt_d = '0;
                        if (out_free) begin
                            frame_done = 1'b1;
                            frame_bits = shifted;
                        end else begin
                            state_d = FULL;
                        end
                    end else begin
                        beat_cnt_d = eff_cnt + CNT_W'(1);
                    end
                end
            end
            FULL: begin
                if (out_free) begin
                    frame_done = 1'b1;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            beat_cnt_q <= '0;
            shift_q    <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            shift_q    <= shift_d;
            sync_err_q <= sync_err_d;
        end
    end
endmodule

// File: rtl/sipo_frame_deser.sv
// Serial-to-parallel frame deserialiser: shift core plus a held output register
// with valid/ready hand-off and a delivered-frame counter.
module sipo_frame_deser
    import sipo_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int LANES      = LANES_DEF,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [LANES-1:0]      in_data,
    output logic                  in_ready,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  sync_err,
    output logic [15:0]           frame_cnt
);
    if (FRAME_BITS % LANES != 0) begin : g_bad_geometry
        $error("FRAME_BITS must be a multiple of LANES");
    end

    logic                  frame_valid_q, frame_valid_d;
    logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  consume, out_free, frame_done;
    logic [FRAME_BITS-1:0] frame_bits;

    // Output slot may be reloaded when empty or emptying this cycle
    assign consume  = frame_valid_q && frame_ready;
    assign out_free = !frame_valid_q || frame_ready;

    sipo_shift_core #(
        .FRAME_BITS(FRAME_BITS),
        .LANES     (LANES),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_free  (out_free),
        .in_ready  (in_ready),
        .frame_done(frame_done),
        .frame_bits(frame_bits),
        .sync_err  (sync_err)
    );

    always_comb begin
        frame_valid_d = frame_valid_q;
        frame_data_d  = frame_data_q;
        frame_cnt_d   = frame_cnt_q + {15'd0, consume};
        if (frame_done) begin
            frame_valid_d = 1'b1;
            frame_data_d  = frame_bits;
        end else if (consume) begin
            frame_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            frame_cnt_q   <= '0;
        end else begin
            frame_valid_q <= frame_valid_d;
            frame_data_q  <= frame_data_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign frame_cnt   = frame_cnt_q;
endmodule
